// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals: requests and bus strobes from the masters,
// grant and status back from the arbiter.
interface bus_arbiter_if #(
    parameter int nrOfMasters = 4
);
    logic [nrOfMasters-1:0] requestBus;
    logic [nrOfMasters-1:0] busGrant;
    logic                   beginTransactionIn;
    logic                   endTransactionIn;
    logic                   busErrorIn;
    logic [2:0]             grantedId;
    logic                   busActive;
    logic                   timeoutPulse;

    modport master (
        output requestBus,
        output beginTransactionIn,
        output endTransactionIn,
        output busErrorIn,
        input  busGrant,
        input  grantedId,
        input  busActive,
        input  timeoutPulse
    );

    modport slave (
        input  requestBus,
        input  beginTransactionIn,
        input  endTransactionIn,
        input  busErrorIn,
        output busGrant,
        output grantedId,
        output busActive,
        output timeoutPulse
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with one turnaround cycle between owners.
// Define ARBITER_TIMEOUT_EN to revoke grants whose begin never arrives.
module bus_arbiter #(
    parameter int nrOfMasters   = 4,
    parameter int timeoutCycles = 32
) (
    input  logic         clock,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANTED = 2'd1;
    localparam logic [1:0] BUSY    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]             state;
    logic [2:0]             last_grant;
    logic [2:0]             granted_id;
    logic [nrOfMasters-1:0] grant;
    logic                   active;
    logic [7:0]             req_pad;
    logic [2:0]             win_id;
    logic                   win_any;
    logic [nrOfMasters-1:0] win_oh;
    logic                   done;
    logic                   held;
    logic                   expired;

    assign req_pad = 8'(bus.requestBus);
    assign win_oh  = {{(nrOfMasters-1){1'b0}}, 1'b1} << win_id;
    assign done    = bus.endTransactionIn | bus.busErrorIn;
    assign held    = req_pad[granted_id];

    // Scan lastGrant+1 .. lastGrant+nrOfMasters, wrapping at nrOfMasters.
    always_comb begin
        logic [3:0] idx;
        idx     = '0;
        win_any = 1'b0;
        win_id  = '0;
        for (int i = 1; i <= nrOfMasters; i++) begin
            idx = {1'b0, last_grant} + 4'(i);
            if (idx >= 4'(nrOfMasters))
                idx = idx - 4'(nrOfMasters);
            if (!win_any && req_pad[idx[2:0]]) begin
                win_any = 1'b1;
                win_id  = idx[2:0];
            end
        end
    end

`ifdef ARBITER_TIMEOUT_EN
    localparam int CW = (timeoutCycles > 2) ? $clog2(timeoutCycles) : 1;

    logic [CW-1:0] wd_cnt;
    logic          pulse;

    assign expired = (wd_cnt == CW'(timeoutCycles - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            pulse  <= 1'b0;
        end else begin
            pulse <= (state == GRANTED) && expired && held &&
                     !bus.beginTransactionIn;
            if (state == GRANTED && !expired)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
        end
    end

    assign bus.timeoutPulse = pulse;
`else
    logic unused_cfg;

    assign expired          = 1'b0;
    assign unused_cfg       = 1'(timeoutCycles);
    assign bus.timeoutPulse = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 3'(nrOfMasters - 1);
            granted_id <= '0;
            grant      <= '0;
            active     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, RELEASE: begin
                    if (win_any) begin
                        state      <= GRANTED;
                        grant      <= win_oh;
                        granted_id <= win_id;
                        last_grant <= win_id;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANTED: begin
                    if (bus.beginTransactionIn && !done) begin
                        state  <= BUSY;
                        active <= 1'b1;
                    end else if (bus.beginTransactionIn || !held || expired) begin
                        state      <= RELEASE;
                        grant      <= '0;
                        granted_id <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state      <= RELEASE;
                        grant      <= '0;
                        granted_id <= '0;
                        active     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busGrant  = grant;
    assign bus.grantedId = granted_id;
    assign bus.busActive = active;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter: sequencing, round-robin order,
// error release, watchdog, single-cycle transactions and async reset.
module tb_bus_arbiter;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bus_arbiter_if #(.nrOfMasters(N)) bus ();

    bus_arbiter #(
        .nrOfMasters  (N),
        .timeoutCycles(32)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic grant_is(input string tag, input logic [3:0] g,
                            input logic [2:0] id);
        check({tag, "_grant"}, 32'(bus.busGrant), 32'(g));
        check({tag, "_id"}, 32'(bus.grantedId), 32'(id));
    endtask

    initial begin
        bus.requestBus         = '0;
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        bus.busErrorIn         = 1'b0;

        #12;
        grant_is("rst", 4'b0000, 3'd0);
        check("rst_active", 32'(bus.busActive), 32'd0);
        check("rst_pulse", 32'(bus.timeoutPulse), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic transaction: begin in cycle 3, end in cycle 6
        bus.requestBus = 4'b0001;
        step();
        grant_is("t1_c1", 4'b0001, 3'd0);
        check("t1_c1_active", 32'(bus.busActive), 32'd0);
        step();
        step();
        bus.beginTransactionIn = 1'b1;
        grant_is("t1_c3", 4'b0001, 3'd0);
        step();
        bus.beginTransactionIn = 1'b0;
        check("t1_c4_active", 32'(bus.busActive), 32'd1);
        step();
        step();
        bus.endTransactionIn = 1'b1;
        grant_is("t1_c6", 4'b0001, 3'd0);
        check("t1_c6_active", 32'(bus.busActive), 32'd1);
        step();
        bus.endTransactionIn = 1'b0;
        bus.requestBus       = 4'b0000;
        grant_is("t1_c7", 4'b0000, 3'd0);
        check("t1_c7_active", 32'(bus.busActive), 32'd0);
        step();
        grant_is("t1_idle", 4'b0000, 3'd0);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;

        // Round robin with all masters requesting
        bus.requestBus = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g;
            g = 4'b0001 << (k % 4);
            grant_is($sformatf("t2_own%0d", k), g, 3'(k % 4));
            bus.beginTransactionIn = 1'b1;
            step();
            bus.beginTransactionIn = 1'b0;
            step();
            check($sformatf("t2_act%0d", k), 32'(bus.busActive), 32'd1);
            step();
            bus.endTransactionIn = 1'b1;
            step();
            bus.endTransactionIn = 1'b0;
            check($sformatf("t2_gap%0d", k), 32'(bus.busGrant), 32'd0);
            check($sformatf("t2_gapact%0d", k), 32'(bus.busActive), 32'd0);
            if (k == 4)
                bus.requestBus = 4'b0000;
            step();
        end
        grant_is("t2_idle", 4'b0000, 3'd0);

        // Error release, master 3 next
        bus.requestBus = 4'b0100;
        step();
        grant_is("t3_m2", 4'b0100, 3'd2);
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        check("t3_active", 32'(bus.busActive), 32'd1);
        bus.requestBus = 4'b1100;
        bus.busErrorIn = 1'b1;
        step();
        bus.busErrorIn = 1'b0;
        grant_is("t3_drop", 4'b0000, 3'd0);
        check("t3_drop_active", 32'(bus.busActive), 32'd0);
        bus.requestBus = 4'b1000;
        step();
        grant_is("t3_m3", 4'b1000, 3'd3);
        bus.requestBus = 4'b0000;
        step();
        grant_is("t3_reqdrop", 4'b0000, 3'd0);
        step();

        // Unused grant: watchdog revoke, or held forever without it
        bus.requestBus = 4'b0110;
        step();
        grant_is("t4_m1", 4'b0010, 3'd1);
`ifdef ARBITER_TIMEOUT_EN
        step(31);
        grant_is("t4_last", 4'b0010, 3'd1);
        check("t4_nopulse", 32'(bus.timeoutPulse), 32'd0);
        step();
        grant_is("t4_revoke", 4'b0000, 3'd0);
        check("t4_pulse", 32'(bus.timeoutPulse), 32'd1);
        step();
        grant_is("t4_m2", 4'b0100, 3'd2);
        check("t4_pulse_end", 32'(bus.timeoutPulse), 32'd0);
`else
        step(39);
        grant_is("t4_held", 4'b0010, 3'd1);
        check("t4_nopulse", 32'(bus.timeoutPulse), 32'd0);
`endif
        bus.requestBus = 4'b0000;
        step();
        grant_is("t4_rel", 4'b0000, 3'd0);
        step();

        // Single-cycle transaction
        bus.requestBus = 4'b0001;
        step();
        grant_is("t5_m0", 4'b0001, 3'd0);
        bus.beginTransactionIn = 1'b1;
        bus.endTransactionIn   = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        bus.endTransactionIn   = 1'b0;
        grant_is("t5_rel", 4'b0000, 3'd0);
        check("t5_active", 32'(bus.busActive), 32'd0);
        bus.requestBus = 4'b0000;
        step();
        check("t5_idle_active", 32'(bus.busActive), 32'd0);

        // Asynchronous reset in BUSY
        bus.requestBus = 4'b0001;
        step();
        grant_is("t6_m0", 4'b0001, 3'd0);
        bus.beginTransactionIn = 1'b1;
        step();
        bus.beginTransactionIn = 1'b0;
        check("t6_busy", 32'(bus.busActive), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        grant_is("t6_async", 4'b0000, 3'd0);
        check("t6_async_active", 32'(bus.busActive), 32'd0);
        bus.requestBus = 4'b1000;
        #1;
        rst_n = 1'b1;
        step();
        grant_is("t6_m3", 4'b1000, 3'd3);
        bus.requestBus = 4'b0000;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
